irq_requester: RTL and testbench
================================

IRQ_REQUESTER -- requirements
Module: irq_requester

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, giving the number of interrupt lines (fixed at 8 for this release).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port event_in, input, 8 bits: peripheral event lines, one per interrupt; an event is a rising edge.
REQ-005 SHALL have port cfg_we, input, 1 bit: register write strobe.
REQ-006 SHALL have port cfg_addr, input, 2 bits: register select.
REQ-007 SHALL have port cfg_wdata, input, 8 bits: register write data.
REQ-008 SHALL have port cfg_rdata, output, 8 bits: combinational register read data.
REQ-009 SHALL have port irq_vector, output, 8 bits: level request lines to the core interrupt unit; bit 7 is the highest priority.
REQ-010 SHALL have port irq_take, input, 1 bit: a one-cycle pulse meaning the core accepted the highest-priority requesting line.
REQ-011 SHALL have port ret, input, 1 bit: a one-cycle pulse meaning the core returned from the current handler.

Function
REQ-012 SHALL keep per-line state IDLE/PENDING/ACTIVE, held as three 8-bit registers: pend, act and mask.
REQ-013 SHALL drive irq_vector = pend & mask, registered-state-derived with no combinational path from irq_take or ret.
REQ-014 SHALL set pend[i] at the clock edge where the edge detector reports a rising edge on event_in[i].
REQ-015 SHALL, on irq_take, select the highest i with irq_vector[i]=1; at that edge pend[i] SHALL clear and act[i] SHALL set.
REQ-016 SHALL ignore irq_take when irq_vector is 0, changing no state.
REQ-017 SHALL, on ret, clear the highest set bit of act (nested return); ret with act=0 SHALL be ignored.
REQ-018 SHALL set sticky ovf[i] when an event edge arrives while pend[i]=1; the event is merged, not queued.
REQ-019 SHALL allow a new event on a line that is ACTIVE: pend[i] sets while act[i] remains set.
REQ-020 SHALL implement this register map:
- addr 0 MASK: read/write.
- addr 1 PENDING: read returns pend; a write of 1 clears the pend and ovf bits at those positions.
- addr 2 ACTIVE: read-only; writes ignored.
- addr 3 read returns ovf; a write of 1 sets the pend bits at those positions (software trigger).
REQ-021 SHALL resolve simultaneous events in the same cycle on the same bit with this priority (highest first): set sources (event edge, software trigger), then clears (write-1-to-clear, irq_take). A take on line i together with an event on i leaves pend[i]=1 and act[i]=1.
REQ-022 SHALL process irq_take and ret asserted in the same cycle as the ret first (clear the highest act bit), then the take.
REQ-023 SHALL mask only irq_vector; pend still records events while mask[i]=0.

Reset
REQ-024 SHALL, while reset is high at a clock edge, clear pend, act, mask, ovf and the edge-detect/synchronizer history to 0; irq_vector SHALL be 0 in the cycle after reset.
REQ-025 SHALL ignore irq_take, ret, event_in and cfg_we while reset is high; reset mid-service drops all active state.
REQ-026 SHALL load the edge-detect history from the current (synchronized) event_in level on the first edge after reset deasserts, so a line already high does not generate an event.

Configuration
REQ-027 SHALL support macro IRQ_SYNC_EN: when defined, each event_in bit passes through a two-flop synchronizer before edge detection, so pend sets 3 edges after event_in rises; when undefined, event_in is edge-detected directly and pend sets 1 edge after the rise.

Structure
REQ-028 SHALL place NUM_IRQ and the register address constants (MASK=0, PENDING=1, ACTIVE=2, OVF_SWTRIG=3) in shared package irq_pkg.
REQ-029 SHALL instantiate a sub-module irq_edge_det that contains the optional synchronizer and the rising-edge detector, and outputs an 8-bit one-cycle edge pulse.

Verification
REQ-030 SHALL cover: mask=0xFF, rising edges on event_in bits 2 and 5 -> irq_vector=0x24; irq_take -> pend=0x04, act=0x20.
REQ-031 SHALL cover: act=0x20, then event on bit 7, irq_take -> act=0xA0; ret -> act=0x20; ret -> act=0x00.
REQ-032 SHALL cover: mask=0x00, event on bit 3 -> irq_vector=0x00, PENDING reads 0x08; write MASK=0x08 -> irq_vector=0x08.
REQ-033 SHALL cover: two events on bit 1 with no take -> OVF reads 0x02; write PENDING=0x02 -> pend and ovf bit 1 cleared.
REQ-034 SHALL cover: same-cycle event edge and PENDING write-1-to-clear on bit 4 -> pend[4]=1; same-cycle irq_take and ret with act=0x01 and pend=0x80 -> act=0x80.
REQ-035 SHALL cover: reset asserted with act=0xFF and pend=0xFF -> all state 0 next cycle; event_in held high across reset -> no pend after release.

Source files
------------

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pkg
//  Purpose  : Shared constants, types and helpers for the interrupt requester.
//             Holds the line count, the register address map and a
//             highest-priority one-hot selector used by take/return logic.
//  Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

  // Number of interrupt lines; fixed at 8 for this release.
  localparam int NUM_IRQ = 8;

  // Register address map.
  localparam logic [1:0] c_ADDR_MASK       = 2'd0;
  localparam logic [1:0] c_ADDR_PENDING    = 2'd1;
  localparam logic [1:0] c_ADDR_ACTIVE     = 2'd2;
  localparam logic [1:0] c_ADDR_OVF_SWTRIG = 2'd3;

  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  // Decoded effect of one register-write cycle.
  typedef struct packed {
    logic     mask_we;  // load MASK from write data
    irq_vec_t w1c;      // write-1-to-clear of pend/ovf
    irq_vec_t swtrig;   // software trigger of pend
  } cfg_wr_t;

  // One-hot of the most significant set bit (bit NUM_IRQ-1 = highest
  // priority). Returns all zeros when no bit is set.
  function automatic irq_vec_t f_highest_onehot(input irq_vec_t v);
    irq_vec_t r;
    r = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : irq_edge_det
//  Purpose  : Rising-edge detector for the peripheral event lines, with an
//             optional two-flop synchronizer in front of it.
//  Config   : IRQ_SYNC_EN - when defined, each line passes through a
//             two-flop synchronizer before edge detection.
//  Ports    : clk     - clock, all state on rising edge
//             rst     - synchronous active-high reset
//             i_level - raw event levels, one per line
//             o_pulse - one-cycle pulse per line on a detected rising edge
//  Revision : 1.0 - initial release
// ============================================================================
module irq_edge_det #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_level,
  output logic [WIDTH-1:0] o_pulse
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] r_prev;
  logic [1:0]       r_arm_cnt;
  logic             w_armed;

`ifdef IRQ_SYNC_EN
  // The history register must see the real synchronized level before any
  // edge is reported, so wait for the two sync stages plus one load.
  localparam logic [1:0] c_ARM_CYCLES = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_level;
      r_sync2 <= r_sync1;
    end
  end

  assign w_level = r_sync2;
`else
  // First edge after reset only loads the history register.
  localparam logic [1:0] c_ARM_CYCLES = 2'd1;

  assign w_level = i_level;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '0;
      r_arm_cnt <= 2'd0;
    end else begin
      r_prev <= w_level;
      if (r_arm_cnt != c_ARM_CYCLES) begin
        r_arm_cnt <= r_arm_cnt + 2'd1;
      end
    end
  end

  // Suppressing pulses until armed keeps a line that is already high when
  // reset releases from being seen as a fresh event.
  assign w_armed = (r_arm_cnt == c_ARM_CYCLES);
  assign o_pulse = w_level & ~r_prev & {WIDTH{w_armed}};

endmodule : irq_edge_det
`default_nettype wire

// File: rtl/irq_requester.sv
`default_nettype none
// ============================================================================
//  Module   : irq_requester
//  Purpose  : Per-line interrupt request tracking (IDLE/PENDING/ACTIVE) with
//             masking, nested take/return handling, sticky overflow flags and
//             a small register interface.
//  Config   : IRQ_SYNC_EN - adds a two-flop synchronizer on event_in
//             (inside irq_edge_det), raising event latency from 1 to 3 edges.
//  Ports    : clk        - clock
//             reset      - synchronous active-high reset
//             event_in   - peripheral event lines (rising edge = event)
//             cfg_we     - register write strobe
//             cfg_addr   - register select (0 MASK, 1 PENDING, 2 ACTIVE,
//                          3 OVF read / software-trigger write)
//             cfg_wdata  - register write data
//             cfg_rdata  - combinational register read data
//             irq_vector - pend & mask, bit 7 highest priority
//             irq_take   - core accepted highest requesting line (pulse)
//             ret        - core returned from current handler (pulse)
//  Revision : 1.0 - initial release
// ============================================================================
module irq_requester
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = irq_pkg::NUM_IRQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] event_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [NUM_IRQ-1:0] cfg_wdata,
  output logic [NUM_IRQ-1:0] cfg_rdata,
  output logic [NUM_IRQ-1:0] irq_vector,
  input  logic               irq_take,
  input  logic               ret
);

  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_act;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_ovf;

  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_req;
  logic               w_take_valid;
  logic [NUM_IRQ-1:0] w_take_sel;
  logic [NUM_IRQ-1:0] w_ret_sel;
  cfg_wr_t            w_wr;
  logic [NUM_IRQ-1:0] w_pend_set;
  logic [NUM_IRQ-1:0] w_pend_clr;
  logic [NUM_IRQ-1:0] w_pend_nxt;
  logic [NUM_IRQ-1:0] w_act_nxt;
  logic [NUM_IRQ-1:0] w_ovf_nxt;

  irq_edge_det #(
    .WIDTH (NUM_IRQ)
  ) u_edge_det (
    .clk     (clk),
    .rst     (reset),
    .i_level (event_in),
    .o_pulse (w_edge)
  );

  // Request lines come only from registered state.
  assign w_req      = r_pend & r_mask;
  assign irq_vector = w_req;

  // A take with nothing requesting selects no line and changes nothing.
  assign w_take_valid = irq_take && (w_req != '0);
  assign w_take_sel   = w_take_valid ? f_highest_onehot(w_req) : '0;

  // Return retires the innermost (highest) active handler; with no active
  // line the selector is zero and the return is a no-op.
  assign w_ret_sel = ret ? f_highest_onehot(r_act) : '0;

  // Register write decode.
  assign w_wr.mask_we = cfg_we && (cfg_addr == c_ADDR_MASK);
  assign w_wr.w1c     = (cfg_we && (cfg_addr == c_ADDR_PENDING))    ? cfg_wdata : '0;
  assign w_wr.swtrig  = (cfg_we && (cfg_addr == c_ADDR_OVF_SWTRIG)) ? cfg_wdata : '0;

  // Set sources win over clear sources on the same bit, so an event that
  // coincides with a take or a W1C still leaves the line pending.
  assign w_pend_set = w_edge | w_wr.swtrig;
  assign w_pend_clr = w_wr.w1c | w_take_sel;
  assign w_pend_nxt = (r_pend & ~w_pend_clr) | w_pend_set;

  // Return is applied before take, so take+ret on the same line keeps it
  // active (the new handler replaces the retired one).
  assign w_act_nxt = (r_act & ~w_ret_sel) | w_take_sel;

  // An edge landing on an already-pending line is merged and flagged.
  assign w_ovf_nxt = (r_ovf & ~w_wr.w1c) | (w_edge & r_pend);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_act  <= '0;
      r_mask <= '0;
      r_ovf  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_act  <= w_act_nxt;
      r_ovf  <= w_ovf_nxt;
      if (w_wr.mask_we) begin
        r_mask <= cfg_wdata;
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      c_ADDR_MASK:       cfg_rdata = r_mask;
      c_ADDR_PENDING:    cfg_rdata = r_pend;
      c_ADDR_ACTIVE:     cfg_rdata = r_act;
      c_ADDR_OVF_SWTRIG: cfg_rdata = r_ovf;
      default:           cfg_rdata = '0;
    endcase
  end

endmodule : irq_requester
`default_nettype wire

// File: tb/tb_irq_requester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_requester
//  Purpose  : Self-checking bench for irq_requester: directed scenarios
//             followed by randomized traffic compared against a per-line
//             behavioural model.
//  Config   : IRQ_SYNC_EN - selects the matching event latency in the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_requester;

`ifdef IRQ_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam int LAT = D + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] event_in;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic [7:0] irq_vector;
  logic       irq_take;
  logic       ret;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  irq_requester #(.NUM_IRQ(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .event_in   (event_in),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .irq_vector (irq_vector),
    .irq_take   (irq_take),
    .ret        (ret)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit       m_pend [8];
  bit       m_act  [8];
  bit       m_mask [8];
  bit       m_ovf  [8];
  bit [7:0] hist[$];
  int       n_since_rst = 0;

  function automatic bit [7:0] pack8(input bit a [8]);
    bit [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[i];
    return r;
  endfunction

  function automatic bit [7:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return pack8(m_mask);
      2'd1:    return pack8(m_pend);
      2'd2:    return pack8(m_act);
      default: return pack8(m_ovf);
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs presently driven.
  task automatic model_step();
    bit [7:0] edges;
    bit [7:0] w1c;
    bit [7:0] trig;
    bit [7:0] lvl_now;
    bit [7:0] lvl_prev;
    bit       old_pend;
    int       take_line;
    int       ret_line;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = 0; m_act[i] = 0; m_mask[i] = 0; m_ovf[i] = 0;
      end
      hist.delete();
      n_since_rst = 0;
      return;
    end
    // Event seen at this edge is the input level D edges ago; the first
    // D+1 edges after reset only establish the reference level.
    hist.push_back(event_in);
    if (hist.size() > D + 2) void'(hist.pop_front());
    if (n_since_rst < 1000) n_since_rst++;
    edges = 8'h00;
    if (n_since_rst >= D + 2) begin
      lvl_now  = hist[hist.size() - 1 - D];
      lvl_prev = hist[hist.size() - 2 - D];
      edges    = lvl_now & ~lvl_prev;
    end
    ret_line = -1;
    if (ret)
      for (int i = 7; i >= 0; i--)
        if (m_act[i] && ret_line < 0) ret_line = i;
    take_line = -1;
    if (irq_take)
      for (int i = 7; i >= 0; i--)
        if (m_pend[i] && m_mask[i] && take_line < 0) take_line = i;
    w1c  = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : 8'h00;
    trig = (cfg_we && cfg_addr == 2'd3) ? cfg_wdata : 8'h00;
    for (int i = 0; i < 8; i++) begin
      old_pend = m_pend[i];
      if (edges[i] || trig[i])             m_pend[i] = 1;
      else if (w1c[i] || take_line == i)   m_pend[i] = 0;
      if (edges[i] && old_pend)            m_ovf[i] = 1;
      else if (w1c[i])                     m_ovf[i] = 0;
      if (ret_line == i)                   m_act[i] = 0;
      if (take_line == i)                  m_act[i] = 1;
      if (cfg_we && cfg_addr == 2'd0)      m_mask[i] = cfg_wdata[i];
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("vector", irq_vector, pack8(m_pend) & pack8(m_mask));
    chk("rdata", cfg_rdata, model_read(cfg_addr));
    irq_take = 1'b0;
    ret      = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
    cfg_addr = a;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; event_in = 8'h00; cfg_we = 1'b0; cfg_addr = 2'd0;
    cfg_wdata = 8'h00; irq_take = 1'b0; ret = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("reset_vector", irq_vector, 8'h00);
    rd(2'd0, 8'h00, "reset_mask");
    rd(2'd1, 8'h00, "reset_pend");
    rd(2'd2, 8'h00, "reset_act");
    rd(2'd3, 8'h00, "reset_ovf");
    reset = 1'b0;
    repeat (D + 2) tick();

    // Two events, take highest.
    wr(2'd0, 8'hFF);
    event_in = 8'h24;
    repeat (LAT) tick();
    chk("two_events_vector", irq_vector, 8'h24);
    irq_take = 1'b1; tick();
    rd(2'd1, 8'h04, "take_pend");
    rd(2'd2, 8'h20, "take_act");

    // Nesting: higher line preempts, then two returns.
    event_in = 8'hA4;
    repeat (LAT) tick();
    irq_take = 1'b1; tick();
    rd(2'd2, 8'hA0, "nest_act");
    ret = 1'b1; tick();
    rd(2'd2, 8'h20, "ret1_act");
    ret = 1'b1; tick();
    rd(2'd2, 8'h00, "ret2_act");
    ret = 1'b1; tick();
    rd(2'd2, 8'h00, "ret_idle_act");
    wr(2'd1, 8'hFF);
    event_in = 8'h00;
    tick();

    // Masked event still records as pending.
    wr(2'd0, 8'h00);
    event_in = 8'h08;
    repeat (LAT) tick();
    chk("masked_vector", irq_vector, 8'h00);
    irq_take = 1'b1; tick();
    rd(2'd1, 8'h08, "masked_pend");
    rd(2'd2, 8'h00, "masked_take_act");
    wr(2'd0, 8'h08);
    chk("unmask_vector", irq_vector, 8'h08);
    wr(2'd1, 8'h08);

    // Overflow: two events on line 1 without a take.
    event_in = 8'h02; repeat (LAT) tick();
    event_in = 8'h00; repeat (LAT) tick();
    event_in = 8'h02; repeat (LAT) tick();
    rd(2'd3, 8'h02, "ovf_set");
    rd(2'd1, 8'h02, "ovf_pend");
    wr(2'd1, 8'h02);
    rd(2'd1, 8'h00, "w1c_pend");
    rd(2'd3, 8'h00, "w1c_ovf");

    // Event edge and W1C on the same bit in the same cycle: set wins.
    event_in = 8'h12;
    repeat (LAT - 1) tick();
    wr(2'd1, 8'h10);
    rd(2'd1, 8'h10, "set_beats_clear");
    wr(2'd1, 8'h10);

    // Take and ret in the same cycle: ret first, then take.
    wr(2'd0, 8'hFF);
    wr(2'd3, 8'h01);
    irq_take = 1'b1; tick();
    wr(2'd3, 8'h80);
    rd(2'd2, 8'h01, "pre_takeret_act");
    irq_take = 1'b1; ret = 1'b1; tick();
    rd(2'd2, 8'h80, "takeret_act");
    rd(2'd1, 8'h00, "takeret_pend");

    // Active read-only.
    wr(2'd2, 8'h00);
    rd(2'd2, 8'h80, "active_ro");

    // Reset mid-service, event line held high across reset.
    wr(2'd3, 8'hFF);
    repeat (8) begin irq_take = 1'b1; tick(); end
    wr(2'd3, 8'hFF);
    rd(2'd2, 8'hFF, "full_act");
    rd(2'd1, 8'hFF, "full_pend");
    event_in = 8'hFF;
    reset = 1'b1;
    tick();
    chk("rst_vector", irq_vector, 8'h00);
    rd(2'd1, 8'h00, "rst_pend");
    rd(2'd2, 8'h00, "rst_act");
    rd(2'd3, 8'h00, "rst_ovf");
    rd(2'd0, 8'h00, "rst_mask");
    reset = 1'b0;
    repeat (D + 4) tick();
    rd(2'd1, 8'h00, "held_high_no_pend");

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0)
        event_in = event_in ^ (8'($urandom()) & 8'($urandom()));
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = 2'($urandom());
      cfg_wdata = 8'($urandom());
      irq_take  = ($urandom_range(0, 2) == 0);
      ret       = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_irq_requester
`default_nettype wire
